// File: rtl/gesture_pkg.sv
// Shared types for the hood power controller: state encoding and default widths.
// Bit 1 of the state is power_state and bit 0 marks an open gesture window.
package gesture_pkg;

  localparam int SEC_W_DEF = 4;

  typedef enum logic [1:0] {
    OFF      = 2'b00,
    OFF_WAIT = 2'b01,
    ON       = 2'b10,
    ON_WAIT  = 2'b11
  } state_t;

  function automatic logic is_on(input state_t s);
    return s[1];
  endfunction

  function automatic logic is_wait(input state_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/gesture_window_timer.sv
// Seconds countdown window: load starts a T-second window, run keeps it counting.
// With run low and no load the counters clear, so sec_left reads 0 while idle.
module gesture_window_timer
  import gesture_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 100000000,
  parameter int SEC_W          = SEC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [SEC_W-1:0] t,
  output logic [SEC_W-1:0] sec_left,
  output logic             expire
);

  localparam int TICK_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CYCLES_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};
  localparam logic [SEC_W-1:0]  SEC_ZERO  = {SEC_W{1'b0}};
  localparam logic [SEC_W-1:0]  SEC_ONE   = {{(SEC_W-1){1'b0}}, 1'b1};

  logic [TICK_W-1:0] tick_r;
  logic [SEC_W-1:0]  sec_r;

  // Expiry is the final cycle of the window; the owner decides what to do with it.
  assign expire   = (tick_r == TICK_ZERO) && (sec_r == SEC_ONE);
  assign sec_left = sec_r;

  // Tick and seconds counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_r <= TICK_ZERO;
      sec_r  <= SEC_ZERO;
    end else if (load) begin
      tick_r <= TICK_MAX;
      sec_r  <= t;
    end else if (run) begin
      if (tick_r != TICK_ZERO) begin
        tick_r <= tick_r - TICK_ONE;
      end else if (sec_r != SEC_ONE) begin
        tick_r <= TICK_MAX;
        sec_r  <= sec_r - SEC_ONE;
      end else begin
        tick_r <= tick_r;
        sec_r  <= sec_r;
      end
    end else begin
      tick_r <= TICK_ZERO;
      sec_r  <= SEC_ZERO;
    end
  end

endmodule

// File: rtl/gesture_power_fsm.sv
// Hood power controller: left-then-right powers on, right-then-left powers off,
// and a long press of power_key toggles power regardless of state.
module gesture_power_fsm
  import gesture_pkg::*;
#(
  parameter int CYCLES_PER_SEC      = 100000000,
  parameter int DEFAULT_TIMEOUT_SEC = 5,
  parameter int LONG_PRESS_CYCLES   = 300000000,
  parameter int SEC_W               = SEC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_key,
  input  logic             right_key,
  input  logic             power_key,
  input  logic [SEC_W-1:0] timeout_sel,
  output logic             power_state,
  output logic             gesture_active,
  output logic [SEC_W-1:0] countdown_sec,
  output logic             power_on_pulse,
  output logic             power_off_pulse
);

  localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [SEC_W-1:0]  SEC_ZERO  = {SEC_W{1'b0}};
  localparam logic [SEC_W-1:0]  DEF_SEC   = SEC_W'(DEFAULT_TIMEOUT_SEC);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              left_d_r;
  logic              right_d_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic              hold_done_r;
  logic              on_pulse_r;
  logic              off_pulse_r;
  logic              left_rise_s;
  logic              right_rise_s;
  logic              long_fire_s;
  logic              load_s;
  logic              run_s;
  logic              on_pulse_s;
  logic              off_pulse_s;
  logic [SEC_W-1:0]  win_len_s;
  logic [SEC_W-1:0]  sec_left_s;
  logic              expire_s;

  assign left_rise_s  = left_key & ~left_d_r;
  assign right_rise_s = right_key & ~right_d_r;
  assign win_len_s    = (timeout_sel == SEC_ZERO) ? DEF_SEC : timeout_sel;
  assign run_s        = is_wait(state_nxt_s);

  // A toggle right after any pulse waits one cycle so pulses never sit back to back.
  assign long_fire_s = power_key & ~hold_done_r & (hold_cnt_r == HOLD_MAX)
                     & ~on_pulse_r & ~off_pulse_r;

  gesture_window_timer #(
    .CYCLES_PER_SEC (CYCLES_PER_SEC),
    .SEC_W          (SEC_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .run      (run_s),
    .t        (win_len_s),
    .sec_left (sec_left_s),
    .expire   (expire_s)
  );

  // Next-state and pulse decode; long press beats gestures, completion beats expiry.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    on_pulse_s  = 1'b0;
    off_pulse_s = 1'b0;
    if (long_fire_s) begin
      if (is_on(state_r)) begin
        state_nxt_s = OFF;
        off_pulse_s = 1'b1;
      end else begin
        state_nxt_s = ON;
        on_pulse_s  = 1'b1;
      end
    end else begin
      case (state_r)
        OFF: begin
          if (left_rise_s && !right_rise_s) begin
            state_nxt_s = OFF_WAIT;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = OFF;
          end
        end
        OFF_WAIT: begin
          if (right_rise_s) begin
            state_nxt_s = ON;
            on_pulse_s  = 1'b1;
          end else if (left_rise_s) begin
            state_nxt_s = OFF_WAIT;
            load_s      = 1'b1;
          end else if (expire_s) begin
            state_nxt_s = OFF;
          end else begin
            state_nxt_s = OFF_WAIT;
          end
        end
        ON: begin
          if (right_rise_s && !left_rise_s) begin
            state_nxt_s = ON_WAIT;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = ON;
          end
        end
        ON_WAIT: begin
          if (left_rise_s) begin
            state_nxt_s = OFF;
            off_pulse_s = 1'b1;
          end else if (right_rise_s) begin
            state_nxt_s = ON_WAIT;
            load_s      = 1'b1;
          end else if (expire_s) begin
            state_nxt_s = ON;
          end else begin
            state_nxt_s = ON_WAIT;
          end
        end
        default: begin
          state_nxt_s = OFF;
        end
      endcase
    end
  end

  // State, pulse and key-edge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= OFF;
      on_pulse_r  <= 1'b0;
      off_pulse_r <= 1'b0;
      left_d_r    <= 1'b0;
      right_d_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      on_pulse_r  <= on_pulse_s;
      off_pulse_r <= off_pulse_s;
      left_d_r    <= left_key;
      right_d_r   <= right_key;
    end
  end

  // Long-press counter; hold_done leaves reset set so a key held through reset must be released first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_r  <= HOLD_ZERO;
      hold_done_r <= 1'b1;
    end else if (!power_key) begin
      hold_cnt_r  <= HOLD_ZERO;
      hold_done_r <= 1'b0;
    end else if (long_fire_s) begin
      hold_cnt_r  <= hold_cnt_r;
      hold_done_r <= 1'b1;
    end else if (!hold_done_r && (hold_cnt_r != HOLD_MAX)) begin
      hold_cnt_r  <= hold_cnt_r + HOLD_ONE;
      hold_done_r <= 1'b0;
    end else begin
      hold_cnt_r  <= hold_cnt_r;
      hold_done_r <= hold_done_r;
    end
  end

  assign power_state     = is_on(state_r);
  assign gesture_active  = is_wait(state_r);
  assign countdown_sec   = sec_left_s;
  assign power_on_pulse  = on_pulse_r;
  assign power_off_pulse = off_pulse_r;

endmodule
